// File: rtl/regfile_sb_pkg.sv
// Shared core defines for the register file: default widths and common constants.
package regfile_sb_pkg;
  localparam int CORE_XLEN    = 64;
  localparam int CORE_REG_NUM = 32;

  localparam logic [CORE_XLEN-1:0] ZERO_WORD     = '0;
  localparam int                   REG_ADDR_ZERO = 0;
  localparam logic                 REG_WR_EN     = 1'b1;
endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending-write (busy) tracking with a registered population count.
module regfile_scoreboard
  import regfile_sb_pkg::*;
#(
  parameter int REG_NUM  = CORE_REG_NUM,
  parameter int WR_PORTS = 2,
  parameter int AW       = $clog2(REG_NUM)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [WR_PORTS-1:0]    i_wr_en,
  input  logic [WR_PORTS*AW-1:0] i_wr_addr,
  input  logic                   i_iss_en,
  input  logic [AW-1:0]          i_iss_addr,
  input  logic                   i_flush,
  output logic [REG_NUM-1:0]     o_busy,
  output logic [AW:0]            o_busy_cnt
);

  logic [REG_NUM-1:0] r_busy;
  logic [AW:0]        r_busy_cnt;
  logic [REG_NUM-1:0] w_busy_nxt;

  function automatic logic [AW:0] popcount(input logic [REG_NUM-1:0] v);
    logic [AW:0] cnt;
    cnt = '0;
    for (int i = 0; i < REG_NUM; i++) cnt = cnt + (AW+1)'(v[i]);
    return cnt;
  endfunction

  // Writes retire producers first so a same-cycle issue re-marks the register busy.
  always_comb begin
    w_busy_nxt = r_busy;
    for (int p = 0; p < WR_PORTS; p++) begin
      if (i_wr_en[p] == REG_WR_EN) w_busy_nxt[i_wr_addr[p*AW +: AW]] = 1'b0;
    end
    if (i_iss_en) w_busy_nxt[i_iss_addr] = 1'b1;
    if (i_flush) w_busy_nxt = '0;
    w_busy_nxt[REG_ADDR_ZERO] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_busy     <= '0;
      r_busy_cnt <= '0;
    end else begin
      r_busy     <= w_busy_nxt;
      r_busy_cnt <= popcount(w_busy_nxt);
    end
  end

  assign o_busy     = r_busy;
  assign o_busy_cnt = r_busy_cnt;

endmodule

// File: rtl/regfile_sb.sv
// Multi-port register file with scoreboard; x0 is hardwired zero.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to matching read ports.
module regfile_sb
  import regfile_sb_pkg::*;
#(
  parameter int XLEN     = CORE_XLEN,
  parameter int REG_NUM  = CORE_REG_NUM,
  parameter int RD_PORTS = 2,
  parameter int WR_PORTS = 2,
  parameter int AW       = $clog2(REG_NUM)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [WR_PORTS-1:0]      wr_en,
  input  logic [WR_PORTS*AW-1:0]   wr_addr,
  input  logic [WR_PORTS*XLEN-1:0] wr_data,
  input  logic [RD_PORTS*AW-1:0]   rd_addr,
  output logic [RD_PORTS*XLEN-1:0] rd_data,
  output logic [RD_PORTS-1:0]      rd_busy,
  input  logic                     iss_en,
  input  logic [AW-1:0]            iss_addr,
  input  logic                     flush,
  output logic [AW:0]              busy_cnt
);

  localparam logic [XLEN-1:0] W_ZERO = XLEN'(ZERO_WORD);
  localparam logic [AW-1:0]   A_ZERO = AW'(REG_ADDR_ZERO);

  logic [XLEN-1:0]    r_regs [REG_NUM];
  logic [REG_NUM-1:0] w_busy;

  regfile_scoreboard #(
    .REG_NUM  (REG_NUM),
    .WR_PORTS (WR_PORTS),
    .AW       (AW)
  ) u_sb (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_wr_en    (wr_en),
    .i_wr_addr  (wr_addr),
    .i_iss_en   (iss_en),
    .i_iss_addr (iss_addr),
    .i_flush    (flush),
    .o_busy     (w_busy),
    .o_busy_cnt (busy_cnt)
  );

  // Later ports overwrite earlier ones, so the highest-index port wins a collision.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_NUM; i++) r_regs[i] <= W_ZERO;
    end else begin
      for (int p = 0; p < WR_PORTS; p++) begin
        if (wr_en[p] == REG_WR_EN && wr_addr[p*AW +: AW] != A_ZERO)
          r_regs[wr_addr[p*AW +: AW]] <= wr_data[p*XLEN +: XLEN];
      end
    end
  end

  always_comb begin
    logic [AW-1:0] w_ra;
    rd_data = '0;
    rd_busy = '0;
    w_ra    = '0;
    for (int r = 0; r < RD_PORTS; r++) begin
      w_ra = rd_addr[r*AW +: AW];
      if (w_ra != A_ZERO) begin
        rd_data[r*XLEN +: XLEN] = r_regs[w_ra];
        rd_busy[r]              = w_busy[w_ra];
`ifdef REGFILE_BYPASS_EN
        for (int p = 0; p < WR_PORTS; p++) begin
          if (wr_en[p] == REG_WR_EN && wr_addr[p*AW +: AW] == w_ra) begin
            rd_data[r*XLEN +: XLEN] = wr_data[p*XLEN +: XLEN];
            rd_busy[r]              = 1'b0;
          end
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed self-checking bench for regfile_sb (default 64-bit, 32 regs, 2R/2W).
module tb_regfile_sb;
  localparam int XLEN = 64;
  localparam int REG_NUM = 32;
  localparam int RD_PORTS = 2;
  localparam int WR_PORTS = 2;
  localparam int AW = 5;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic [WR_PORTS-1:0]      wr_en;
  logic [WR_PORTS*AW-1:0]   wr_addr;
  logic [WR_PORTS*XLEN-1:0] wr_data;
  logic [RD_PORTS*AW-1:0]   rd_addr;
  logic [RD_PORTS*XLEN-1:0] rd_data;
  logic [RD_PORTS-1:0]      rd_busy;
  logic                     iss_en;
  logic [AW-1:0]            iss_addr;
  logic                     flush;
  logic [AW:0]              busy_cnt;

  int total = 0;
  int bad = 0;

  regfile_sb #(
    .XLEN(XLEN), .REG_NUM(REG_NUM), .RD_PORTS(RD_PORTS), .WR_PORTS(WR_PORTS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy), .iss_en(iss_en),
    .iss_addr(iss_addr), .flush(flush), .busy_cnt(busy_cnt)
  );

  always #5 clk = ~clk;

  task automatic idle();
    wr_en = '0; wr_addr = '0; wr_data = '0;
    iss_en = 1'b0; iss_addr = '0; flush = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wr(input int p, input logic [AW-1:0] a, input logic [XLEN-1:0] d);
    wr_en[p] = 1'b1;
    wr_addr[p*AW +: AW] = a;
    wr_data[p*XLEN +: XLEN] = d;
  endtask

  task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    rd_addr[0 +: AW] = a0;
    rd_addr[AW +: AW] = a1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; idle(); set_rd(5'd5, 5'd0);
    tick(); tick();
    rst_n = 1'b1;
    #1;
    total++;
    if (busy_cnt !== 6'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", busy_cnt); end
    total++;
    if (rd_data[0 +: XLEN] !== 64'h0) begin bad++; $display("FAIL reset_x5 got=%h exp=0", rd_data[0 +: XLEN]); end
    total++;
    if (rd_busy !== 2'b00) begin bad++; $display("FAIL reset_busy got=%b exp=00", rd_busy); end
  endtask

  task automatic test_write_read();
    idle(); set_wr(0, 5'd5, 64'h1234);
    set_wr(1, 5'd0, 64'hDEAD);
    tick(); idle(); set_rd(5'd5, 5'd0);
    #1;
    total++;
    if (rd_data[0 +: XLEN] !== 64'h1234) begin bad++; $display("FAIL wr_x5 got=%h exp=1234", rd_data[0 +: XLEN]); end
    total++;
    if (rd_data[XLEN +: XLEN] !== 64'h0) begin bad++; $display("FAIL rd_x0 got=%h exp=0", rd_data[XLEN +: XLEN]); end
  endtask

  task automatic test_same_addr();
    idle(); set_wr(0, 5'd7, 64'hAA); set_wr(1, 5'd7, 64'hBB);
    tick(); idle(); set_rd(5'd7, 5'd7);
    #1;
    total++;
    if (rd_data[0 +: XLEN] !== 64'hBB) begin bad++; $display("FAIL collide_p0 got=%h exp=bb", rd_data[0 +: XLEN]); end
    total++;
    if (rd_data[XLEN +: XLEN] !== 64'hBB) begin bad++; $display("FAIL collide_p1 got=%h exp=bb", rd_data[XLEN +: XLEN]); end
  endtask

  task automatic test_busy();
    idle(); iss_en = 1'b1; iss_addr = 5'd3;
    tick(); idle(); set_rd(5'd3, 5'd0);
    #1;
    total++;
    if (rd_busy !== 2'b01) begin bad++; $display("FAIL iss_busy got=%b exp=01", rd_busy); end
    total++;
    if (busy_cnt !== 6'd1) begin bad++; $display("FAIL iss_cnt got=%0d exp=1", busy_cnt); end
    set_wr(0, 5'd3, 64'h33);
    tick(); idle();
    #1;
    total++;
    if (rd_busy[0] !== 1'b0) begin bad++; $display("FAIL wr_clear got=%b exp=0", rd_busy[0]); end
    total++;
    if (busy_cnt !== 6'd0) begin bad++; $display("FAIL wr_clear_cnt got=%0d exp=0", busy_cnt); end
    set_wr(1, 5'd3, 64'h44); iss_en = 1'b1; iss_addr = 5'd3;
    tick(); idle();
    #1;
    total++;
    if (rd_busy[0] !== 1'b1) begin bad++; $display("FAIL iss_wr_busy got=%b exp=1", rd_busy[0]); end
    total++;
    if (busy_cnt !== 6'd1) begin bad++; $display("FAIL iss_wr_cnt got=%0d exp=1", busy_cnt); end
    total++;
    if (rd_data[0 +: XLEN] !== 64'h44) begin bad++; $display("FAIL iss_wr_data got=%h exp=44", rd_data[0 +: XLEN]); end
    iss_en = 1'b1; iss_addr = 5'd0;
    tick(); idle(); set_rd(5'd0, 5'd3);
    #1;
    total++;
    if (busy_cnt !== 6'd1) begin bad++; $display("FAIL iss_x0_cnt got=%0d exp=1", busy_cnt); end
    total++;
    if (rd_busy !== 2'b10) begin bad++; $display("FAIL iss_x0_busy got=%b exp=10", rd_busy); end
    set_wr(0, 5'd3, 64'h0);
    tick(); idle();
  endtask

  task automatic test_flush();
    idle(); iss_en = 1'b1; iss_addr = 5'd1; tick();
    iss_addr = 5'd2; tick();
    iss_addr = 5'd4; tick();
    idle(); set_rd(5'd1, 5'd4);
    #1;
    total++;
    if (busy_cnt !== 6'd3) begin bad++; $display("FAIL pre_flush_cnt got=%0d exp=3", busy_cnt); end
    total++;
    if (rd_busy !== 2'b11) begin bad++; $display("FAIL pre_flush_busy got=%b exp=11", rd_busy); end
    flush = 1'b1; iss_en = 1'b1; iss_addr = 5'd9;
    set_wr(0, 5'd20, 64'hF00D);
    tick(); idle(); set_rd(5'd9, 5'd20);
    #1;
    total++;
    if (busy_cnt !== 6'd0) begin bad++; $display("FAIL flush_cnt got=%0d exp=0", busy_cnt); end
    total++;
    if (rd_busy !== 2'b00) begin bad++; $display("FAIL flush_busy got=%b exp=00", rd_busy); end
    total++;
    if (rd_data[XLEN +: XLEN] !== 64'hF00D) begin bad++; $display("FAIL flush_wr got=%h exp=f00d", rd_data[XLEN +: XLEN]); end
  endtask

  task automatic test_bypass();
    idle(); set_wr(0, 5'd6, 64'h11); tick();
    idle(); iss_en = 1'b1; iss_addr = 5'd6; tick();
    idle(); set_rd(5'd6, 5'd6); set_wr(0, 5'd6, 64'h55);
    #1;
`ifdef REGFILE_BYPASS_EN
    total++;
    if (rd_data[0 +: XLEN] !== 64'h55) begin bad++; $display("FAIL byp_data got=%h exp=55", rd_data[0 +: XLEN]); end
    total++;
    if (rd_busy !== 2'b00) begin bad++; $display("FAIL byp_busy got=%b exp=00", rd_busy); end
`else
    total++;
    if (rd_data[0 +: XLEN] !== 64'h11) begin bad++; $display("FAIL nobyp_data got=%h exp=11", rd_data[0 +: XLEN]); end
    total++;
    if (rd_busy !== 2'b11) begin bad++; $display("FAIL nobyp_busy got=%b exp=11", rd_busy); end
`endif
    total++;
    if (rd_data[XLEN +: XLEN] !== rd_data[0 +: XLEN]) begin bad++; $display("FAIL rd_ports_same got=%h exp=%h", rd_data[XLEN +: XLEN], rd_data[0 +: XLEN]); end
    tick(); idle();
    #1;
    total++;
    if (rd_data[0 +: XLEN] !== 64'h55) begin bad++; $display("FAIL post_wr_data got=%h exp=55", rd_data[0 +: XLEN]); end
    total++;
    if (rd_busy !== 2'b00) begin bad++; $display("FAIL post_wr_busy got=%b exp=00", rd_busy); end
    set_rd(5'd0, 5'd0); set_wr(0, 5'd0, 64'hFF); iss_en = 1'b1; iss_addr = 5'd0;
    #1;
    total++;
    if (rd_data[0 +: XLEN] !== 64'h0) begin bad++; $display("FAIL x0_wr_same got=%h exp=0", rd_data[0 +: XLEN]); end
    tick(); idle();
    #1;
    total++;
    if (rd_data[0 +: XLEN] !== 64'h0 || rd_busy !== 2'b00) begin bad++; $display("FAIL x0_wr_after got=%h/%b exp=0/00", rd_data[0 +: XLEN], rd_busy); end
  endtask

  task automatic test_reset_mid();
    idle(); iss_en = 1'b1; iss_addr = 5'd10; set_wr(0, 5'd12, 64'h99);
    tick();
    idle(); rst_n = 1'b0;
    set_wr(0, 5'd13, 64'h77); set_wr(1, 5'd14, 64'h66);
    iss_en = 1'b1; iss_addr = 5'd15;
    tick();
    rst_n = 1'b1; idle(); set_rd(5'd12, 5'd15);
    #1;
    total++;
    if (busy_cnt !== 6'd0) begin bad++; $display("FAIL rst_mid_cnt got=%0d exp=0", busy_cnt); end
    total++;
    if (rd_data[0 +: XLEN] !== 64'h0) begin bad++; $display("FAIL rst_mid_x12 got=%h exp=0", rd_data[0 +: XLEN]); end
    total++;
    if (rd_busy !== 2'b00) begin bad++; $display("FAIL rst_mid_busy got=%b exp=00", rd_busy); end
    set_rd(5'd13, 5'd14);
    #1;
    total++;
    if (rd_data !== 128'h0) begin bad++; $display("FAIL rst_mid_wr got=%h exp=0", rd_data); end
    set_rd(5'd5, 5'd7);
    #1;
    total++;
    if (rd_data !== 128'h0) begin bad++; $display("FAIL rst_mid_old got=%h exp=0", rd_data); end
  endtask

  initial begin
    rst_n = 1'b0; rd_addr = '0; idle();
    test_reset();
    test_write_read();
    test_same_addr();
    test_busy();
    test_flush();
    test_bypass();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL have parameter XLEN, default 64, data width per register.
REQ-002 SHALL have parameter REG_NUM, default 32, number of architectural registers (power of two, >=2); AW = clog2(REG_NUM).
REQ-003 SHALL have parameter RD_PORTS, default 2, number of read ports (1..4).
REQ-004 SHALL have parameter WR_PORTS, default 2, number of write ports (1..2).
REQ-005 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-006 SHALL have port rst_n  input  1  reset; synchronous, active-low.
REQ-007 SHALL have port wr_en  input  WR_PORTS  per-port write enable.
REQ-008 SHALL have port wr_addr  input  WR_PORTS*AW  per-port write address, port p at bits [p*AW +: AW].
REQ-009 SHALL have port wr_data  input  WR_PORTS*XLEN  per-port write data.
REQ-010 SHALL have port rd_addr  input  RD_PORTS*AW  per-port read address.
REQ-011 SHALL have port rd_data  output  RD_PORTS*XLEN  per-port read data, combinational.
REQ-012 SHALL have port rd_busy  output  RD_PORTS  per-port pending-write flag for rd_addr, combinational.
REQ-013 SHALL have port iss_en  input  1  an instruction with destination iss_addr issues this cycle.
REQ-014 SHALL have port iss_addr  input  AW  destination register of issuing instruction.
REQ-015 SHALL have port flush  input  1  discard all pending writes (pipeline flush).
REQ-016 SHALL have port busy_cnt  output  AW+1  registered count of busy registers.

Function
REQ-017 SHALL write wr_data[p] into register wr_addr[p] on the clock edge when wr_en[p]=1 and wr_addr[p]!=0.
REQ-018 SHALL, when both write ports target the same nonzero address in one cycle, store port WR_PORTS-1 data (higher index wins).
REQ-019 SHALL return zero on rd_data and 0 on rd_busy for any read port addressing register 0, regardless of writes or issue.
REQ-020 SHALL keep one busy bit per register; bit 0 is constant 0.
REQ-021 SHALL set busy[iss_addr] on the edge following iss_en=1 with iss_addr!=0.
REQ-022 SHALL clear busy[a] on the edge following any wr_en[p]=1 with wr_addr[p]=a.
REQ-023 SHALL, on simultaneous issue and write to the same address, leave busy set (new producer wins).
REQ-024 SHALL, on flush=1, clear all busy bits on the next edge, including an issue in the same cycle; writes in that cycle still update register contents.
REQ-025 SHALL update busy_cnt one edge after the busy-vector change, equal to the population count of the next-state busy vector; range 0..REG_NUM-1.
REQ-026 SHALL allow any number of read ports to address the same register simultaneously with identical results.

Reset
REQ-027 SHALL, while rst_n=0 at a clock edge, clear all registers to zero, all busy bits to 0 and busy_cnt to 0, overriding write, issue and flush in that cycle.
REQ-028 SHALL keep rd_data and rd_busy combinational from reset-cleared state; no other output reset value is needed.

Configuration
REQ-029 SHALL, with macro REGFILE_BYPASS_EN defined, forward same-cycle wr_data to any read port whose rd_addr matches an enabled nonzero write (REQ-018 priority applies) and force that port's rd_busy to 0.
REQ-030 SHALL, without REGFILE_BYPASS_EN, return only stored contents on rd_data and registered busy on rd_busy (write visible from next cycle).

Structure
REQ-031 SHALL take ZERO_WORD, REG_ADDR_ZERO, REG_WR_EN and default XLEN/REG_NUM from the shared core defines package.
REQ-032 SHALL implement busy tracking and busy_cnt in sub-module regfile_scoreboard; storage and read muxing stay in regfile_sb.

Verification
REQ-033 SHALL cover: reset, then write x5=0x1234 via port 0 -> next cycle rd_addr=5 returns 0x1234; rd_addr=0 returns 0.
REQ-034 SHALL cover: both ports write x7 (0xAA port 0, 0xBB port 1) same cycle -> x7 reads 0xBB.
REQ-035 SHALL cover: iss_en x3 -> next cycle rd_busy=1, busy_cnt=1; write x3 -> next cycle rd_busy=0, busy_cnt=0; issue+write x3 same cycle -> busy stays 1.
REQ-036 SHALL cover: issue x1,x2,x4 then flush with issue x9 -> busy_cnt=0, all rd_busy=0.
REQ-037 SHALL cover with REGFILE_BYPASS_EN: busy x6, write x6=0x55 while reading x6 -> same cycle rd_data=0x55, rd_busy=0; without macro -> old value and rd_busy=1 that cycle.
REQ-038 SHALL cover: rst_n=0 asserted mid-sequence with pending busy bits and writes -> next edge all registers 0, busy_cnt=0.
